// File: rtl/vga_write_scheduler_if.sv
// Write-port bundle between the frame-memory write scheduler and its requesters.
// Carries both requester handshakes, the screen-clear control and the packed memory write word.
`timescale 1ns/1ps
interface vga_write_scheduler_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 4
);
    logic              clear_start;
    logic [DATA_W-1:0] clear_color;
    logic              clear_busy;

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic [31:0]       write_reg;
    logic              range_error;

    modport slave (
        input  clear_start, clear_color,
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output clear_busy, a_ready, b_ready, write_reg, range_error
    );

    modport master (
        output clear_start, clear_color,
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  clear_busy, a_ready, b_ready, write_reg, range_error
    );
endinterface

// File: rtl/vga_write_scheduler.sv
// Single write-port scheduler for the VGA frame memory: round-robin between the Sobel
// stream (A) and the processor writer (B), plus a full-screen clear sequencer.
//
// state | meaning
// ARB   | requesters arbitrated round-robin; clear_start launches a clear
// CLEAR | one clear write per cycle, counter 0..PIXEL_COUNT-1; requesters stalled
`timescale 1ns/1ps
module vga_write_scheduler #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 4,
    parameter int PIXEL_COUNT = 307200
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    vga_write_scheduler_if.slave  bus
);
    localparam int PAD_W = 32 - 1 - DATA_W - ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_COUNT - 1);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t            state_q, state_d;
    logic              last_grant_b_q;
    logic [ADDR_W-1:0] count_q;
    logic [DATA_W-1:0] color_q;
    logic [31:0]       write_reg_q;
    logic              range_error_q;

    logic              a_ready, b_ready;
    logic              clear_go, clear_last;
    logic              fire;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_in_range;

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Readies are held low during reset so nothing can transfer while the block is cleared.
    always_comb begin
        state_d    = state_q;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        clear_go   = 1'b0;
        clear_last = 1'b0;
        case (state_q)
            ARB: begin
                if (bus.clear_start) begin
                    state_d  = CLEAR;
                    clear_go = 1'b1;
                end else if (!reset) begin
                    a_ready = bus.a_valid && (!bus.b_valid || last_grant_b_q);
                    b_ready = bus.b_valid && (!bus.a_valid || !last_grant_b_q);
                end
            end
            CLEAR: begin
                if (count_q == LAST_ADDR) begin
                    clear_last = 1'b1;
                    state_d    = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        fire         = a_ready || b_ready;
        win_addr     = b_ready ? bus.b_addr : bus.a_addr;
        win_data     = b_ready ? bus.b_data : bus.a_data;
        win_in_range = (win_addr <= LAST_ADDR);
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            write_reg_q    <= 32'd0;
            range_error_q  <= 1'b0;
            count_q        <= '0;
            color_q        <= '0;
            last_grant_b_q <= 1'b1;
        end else begin
            write_reg_q   <= 32'd0;
            range_error_q <= 1'b0;
            if (clear_go) begin
                color_q <= bus.clear_color;
                count_q <= '0;
            end
            // The counter parks on the last address so it never runs past the screen.
            if (state_q == CLEAR) begin
                write_reg_q <= {{PAD_W{1'b0}}, 1'b1, color_q, count_q};
                if (!clear_last) begin
                    count_q <= count_q + 1'b1;
                end
            end
            if (fire) begin
                last_grant_b_q <= b_ready;
                if (win_in_range) begin
                    write_reg_q <= {{PAD_W{1'b0}}, 1'b1, win_data, win_addr};
                end else begin
                    range_error_q <= 1'b1;
                end
            end
        end
    end

    assign bus.a_ready     = a_ready;
    assign bus.b_ready     = b_ready;
    assign bus.clear_busy  = (state_q == CLEAR);
    assign bus.write_reg   = write_reg_q;
    assign bus.range_error = range_error_q;

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Directed bench for vga_write_scheduler; a reduced PIXEL_COUNT keeps full clears short.
`timescale 1ns/1ps
module tb_vga_write_scheduler;
    localparam int PC = 1024;

    logic sys_clock;
    logic reset;
    int   errors;
    int   checks;

    vga_write_scheduler_if #(.ADDR_W(20), .DATA_W(4)) bus ();

    vga_write_scheduler #(.ADDR_W(20), .DATA_W(4), .PIXEL_COUNT(PC)) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .bus       (bus)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    task automatic idle_inputs();
        bus.clear_start = 1'b0;
        bus.clear_color = 4'h0;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    endtask

    task automatic after_edge();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.a_valid = 1'b1; bus.a_addr = 20'd10; bus.a_data = 4'h1;
        after_edge();
        checks++;
        if (bus.write_reg !== 32'd0 || bus.a_ready !== 1'b0 || bus.clear_busy !== 1'b0 || bus.range_error !== 1'b0) begin
            $display("FAIL reset_values: write_reg=%h a_ready=%b busy=%b rerr=%b, need 0/0/0/0",
                     bus.write_reg, bus.a_ready, bus.clear_busy, bus.range_error);
            errors++;
        end
        @(negedge sys_clock);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: a_ready=%b need 1", bus.a_ready);
            errors++;
        end
        after_edge();
        checks++;
        if (bus.write_reg !== 32'h0110000A) begin
            $display("FAIL stream_write: write_reg=%h need 0110000a", bus.write_reg);
            errors++;
        end
        // Asynchronous reset mid-stream, away from any clock edge
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.write_reg !== 32'd0 || bus.a_ready !== 1'b0 || bus.clear_busy !== 1'b0) begin
            $display("FAIL reset_midstream: write_reg=%h a_ready=%b busy=%b, need 0/0/0",
                     bus.write_reg, bus.a_ready, bus.clear_busy);
            errors++;
        end
        @(negedge sys_clock);
        bus.b_valid = 1'b1; bus.b_addr = 20'd20; bus.b_data = 4'h2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            $display("FAIL reset_tie_a_first: a_ready=%b b_ready=%b, need 1/0", bus.a_ready, bus.b_ready);
            errors++;
        end
        @(negedge sys_clock);
        idle_inputs();
        after_edge();
    endtask

    task automatic test_single();
        @(negedge sys_clock);
        bus.a_valid = 1'b1; bus.a_addr = 20'd100; bus.a_data = 4'hA;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            $display("FAIL single_ready: a_ready=%b b_ready=%b, need 1/0", bus.a_ready, bus.b_ready);
            errors++;
        end
        after_edge();
        checks++;
        if (bus.write_reg !== 32'h01A00064) begin
            $display("FAIL single_write: write_reg=%h need 01a00064", bus.write_reg);
            errors++;
        end
        @(negedge sys_clock);
        bus.a_valid = 1'b0;
        after_edge();
        checks++;
        if (bus.write_reg !== 32'd0) begin
            $display("FAIL single_idle: write_reg=%h need 0", bus.write_reg);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        // B-only write first so the following tie starts with A
        @(negedge sys_clock);
        bus.b_valid = 1'b1; bus.b_addr = 20'd3; bus.b_data = 4'h0;
        after_edge();
        checks++;
        if (bus.write_reg !== 32'h01000003) begin
            $display("FAIL rr_b_single: write_reg=%h need 01000003", bus.write_reg);
            errors++;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clock);
            if (i == 0) begin
                bus.a_valid = 1'b1; bus.a_addr = 20'd1; bus.a_data = 4'h3;
                bus.b_valid = 1'b1; bus.b_addr = 20'd2; bus.b_data = 4'h5;
            end
            #1;
            checks++;
            if (bus.a_ready !== (i % 2 == 0) || bus.b_ready !== (i % 2 == 1)) begin
                $display("FAIL rr_grant[%0d]: a_ready=%b b_ready=%b, need %b/%b",
                         i, bus.a_ready, bus.b_ready, (i % 2 == 0), (i % 2 == 1));
                errors++;
            end
            after_edge();
            checks++;
            if (bus.write_reg !== ((i % 2 == 0) ? 32'h01300001 : 32'h01500002)) begin
                $display("FAIL rr_write[%0d]: write_reg=%h need %h", i, bus.write_reg,
                         ((i % 2 == 0) ? 32'h01300001 : 32'h01500002));
                errors++;
            end
        end
        @(negedge sys_clock);
        idle_inputs();
        after_edge();
        checks++;
        if (bus.write_reg !== 32'd0) begin
            $display("FAIL rr_idle: write_reg=%h need 0", bus.write_reg);
            errors++;
        end
    endtask

    task automatic test_range_error();
        @(negedge sys_clock);
        bus.b_valid = 1'b1; bus.b_addr = 20'(PC - 1); bus.b_data = 4'h2;
        after_edge();
        checks++;
        if (bus.write_reg !== 32'h012003FF || bus.range_error !== 1'b0) begin
            $display("FAIL range_last_valid: write_reg=%h rerr=%b, need 012003ff/0", bus.write_reg, bus.range_error);
            errors++;
        end
        @(negedge sys_clock);
        idle_inputs();
        bus.a_valid = 1'b1; bus.a_addr = 20'd7; bus.a_data = 4'h4;
        after_edge();
        checks++;
        if (bus.write_reg !== 32'h01400007) begin
            $display("FAIL range_a_write: write_reg=%h need 01400007", bus.write_reg);
            errors++;
        end
        @(negedge sys_clock);
        idle_inputs();
        bus.b_valid = 1'b1; bus.b_addr = 20'(PC); bus.b_data = 4'hF;
        #1;
        checks++;
        if (bus.b_ready !== 1'b1) begin
            $display("FAIL range_accept: b_ready=%b need 1", bus.b_ready);
            errors++;
        end
        after_edge();
        checks++;
        if (bus.write_reg !== 32'd0 || bus.range_error !== 1'b1) begin
            $display("FAIL range_pulse: write_reg=%h rerr=%b, need 0/1", bus.write_reg, bus.range_error);
            errors++;
        end
        @(negedge sys_clock);
        idle_inputs();
        after_edge();
        checks++;
        if (bus.range_error !== 1'b0) begin
            $display("FAIL range_one_cycle: rerr=%b need 0", bus.range_error);
            errors++;
        end
        // The rejected B transfer still counts as B's turn, so A wins this tie
        @(negedge sys_clock);
        bus.a_valid = 1'b1; bus.a_addr = 20'd8; bus.a_data = 4'h1;
        bus.b_valid = 1'b1; bus.b_addr = 20'd9; bus.b_data = 4'h1;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            $display("FAIL range_last_grant: a_ready=%b b_ready=%b, need 1/0", bus.a_ready, bus.b_ready);
            errors++;
        end
        @(negedge sys_clock);
        idle_inputs();
        after_edge();
    endtask

    task automatic test_full_clear();
        logic [31:0] exp_w;
        @(negedge sys_clock);
        bus.a_valid = 1'b1; bus.a_addr = 20'd50; bus.a_data = 4'h9;
        bus.clear_start = 1'b1; bus.clear_color = 4'h7;
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || bus.clear_busy !== 1'b0) begin
            $display("FAIL clear_start_cycle: a_ready=%b busy=%b, need 0/0", bus.a_ready, bus.clear_busy);
            errors++;
        end
        after_edge();
        bus.clear_start = 1'b0;
        bus.clear_color = 4'h3;
        for (int j = 1; j <= PC + 1; j++) begin
            if (j == 100) bus.clear_start = 1'b1;
            if (j == 101) bus.clear_start = 1'b0;
            exp_w = (j >= 2) ? (32'h01700000 | 32'(j - 2)) : 32'd0;
            checks++;
            if (bus.write_reg !== exp_w || bus.clear_busy !== (j <= PC) ||
                bus.a_ready !== (j == PC + 1) || bus.b_ready !== 1'b0) begin
                $display("FAIL clear_cycle[%0d]: write_reg=%h busy=%b a_ready=%b b_ready=%b, need %h/%b/%b/0",
                         j, bus.write_reg, bus.clear_busy, bus.a_ready, bus.b_ready,
                         exp_w, (j <= PC), (j == PC + 1));
                errors++;
            end
            if (j <= PC) after_edge();
        end
        after_edge();
        bus.a_valid = 1'b0;
        checks++;
        if (bus.write_reg !== 32'h01900032 || bus.clear_busy !== 1'b0) begin
            $display("FAIL clear_then_a: write_reg=%h busy=%b, need 01900032/0", bus.write_reg, bus.clear_busy);
            errors++;
        end
        after_edge();
        checks++;
        if (bus.write_reg !== 32'd0 || bus.clear_busy !== 1'b0) begin
            $display("FAIL clear_no_restart: write_reg=%h busy=%b, need 0/0", bus.write_reg, bus.clear_busy);
            errors++;
        end
    endtask

    task automatic test_reset_during_clear();
        bit seen;
        seen = 1'b0;
        @(negedge sys_clock);
        bus.clear_start = 1'b1; bus.clear_color = 4'h5;
        after_edge();
        bus.clear_start = 1'b0;
        for (int k = 0; k < 700 && !seen; k++) begin
            after_edge();
            if (bus.write_reg === (32'h01500000 | 32'd500)) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            $display("FAIL clear_reach_500: write_reg=%h, address 500 never written", bus.write_reg);
            errors++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.write_reg !== 32'd0 || bus.clear_busy !== 1'b0) begin
            $display("FAIL clear_reset_abort: write_reg=%h busy=%b, need 0/0", bus.write_reg, bus.clear_busy);
            errors++;
        end
        @(negedge sys_clock);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            after_edge();
            checks++;
            if (bus.write_reg !== 32'd0 || bus.clear_busy !== 1'b0) begin
                $display("FAIL clear_no_resume[%0d]: write_reg=%h busy=%b, need 0/0", k, bus.write_reg, bus.clear_busy);
                errors++;
            end
        end
        @(negedge sys_clock);
        bus.clear_start = 1'b1; bus.clear_color = 4'h6;
        after_edge();
        bus.clear_start = 1'b0;
        after_edge();
        checks++;
        if (bus.write_reg !== 32'h01600000 || bus.clear_busy !== 1'b1) begin
            $display("FAIL clear_restart: write_reg=%h busy=%b, need 01600000/1", bus.write_reg, bus.clear_busy);
            errors++;
        end
        reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_range_error();
        test_full_clear();
        test_reset_during_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_write_scheduler.md
Name: vga_write_scheduler

Overview:
Single write-port scheduler in front of the VGA frame memory. It shares the memory write path between two requesters: A, the Sobel pixel output stream, and B, the processor/debug writer. It also runs a built-in screen-clear sequencer that fills all 640x480 locations with one colour. Its output is the packed write_reg word consumed by vga_controller (19:0 address, 23:20 data), plus a write strobe on bit 24.

Parameters:
ADDR_W, 20, pixel address width
DATA_W, 4, pixel data width
PIXEL_COUNT, 307200, number of valid addresses (640*480); valid range 0..PIXEL_COUNT-1

Ports:
sys_clock  in  1  system clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset
clear_start  in  1  one-cycle request to clear the screen
clear_color  in  DATA_W  fill colour, sampled together with clear_start
clear_busy  out  1  high while the clear sequence runs
a_valid  in  1  requester A (Sobel) write request
a_addr  in  ADDR_W  requester A address
a_data  in  DATA_W  requester A pixel
a_ready  out  1  requester A grant/accept
b_valid  in  1  requester B (processor) write request
b_addr  in  ADDR_W  requester B address
b_data  in  DATA_W  requester B pixel
b_ready  out  1  requester B grant/accept
write_reg  out  32  to VGA memory: 19:0 address, 23:20 data, 24 write strobe, 31:25 zero
range_error  out  1  one-cycle pulse: an accepted request had an out-of-range address

Behaviour:
- Reset values (asynchronous, while reset=1): state=ARB, write_reg=0, clear_busy=0, range_error=0, clear counter=0, last_grant=B (so A wins the first tie). A reset during CLEAR aborts the clear; no further clear writes are issued.
- States: ARB, CLEAR. Both requesters are serviced only in ARB.
- Handshake: a request transfers on a cycle with valid=1 and ready=1. A requester holds addr/data stable while valid=1 and ready=0. Ready is combinational from state, valids, clear_start and last_grant.
- ARB grant rules:
  - At most one ready per cycle.
  - If clear_start=1, both readies=0 that cycle.
  - Otherwise, if only one requester is valid, it is granted.
  - If both are valid, the requester other than last_grant is granted (round-robin).
  - If neither is valid, both readies=0.
  - last_grant updates to the winner on every transfer.
- Write latency: 1 cycle. A transfer in cycle T drives write_reg={7'b0,1'b1,data,addr} during T+1. A cycle with no write drives write_reg=32'd0.
- Range check: if a transfer has addr >= PIXEL_COUNT, the request is still accepted (ready=1). The next cycle drives write_reg=0 and range_error=1 for one cycle, and last_grant still updates.
- Clear start: clear_start=1 in ARB during cycle T:
  - latches clear_color and sets counter=0;
  - state=CLEAR and clear_busy=1 from T+1.
- Clear sequence: each CLEAR cycle registers a write with address=counter and data=latched colour, then increments counter. Address 0 appears on write_reg in T+2.
- Clear end: on the cycle counter==PIXEL_COUNT-1, the state returns to ARB. The last write (address PIXEL_COUNT-1) appears in T+PIXEL_COUNT+1, with clear_busy=0 and readies eligible in that same cycle.
- Clear priority: clear_start during CLEAR is ignored. a_ready=b_ready=0 for the whole time clear_busy=1. Pending valids wait and are unaffected.
- Colour stability: a clear_color change during CLEAR has no effect on the running clear.
- Counter width: the counter is ADDR_W bits and never wraps past PIXEL_COUNT-1.

Test Plan:
- Reset mid-stream: assert reset while a_valid=1 -> write_reg=0, a_ready=0, clear_busy=0 immediately; after release, A is granted first on a tie.
- Single requester: a_valid=1, a_addr=100, a_data=4'hA for one cycle -> a_ready=1 that cycle, write_reg=32'h01A00064 next cycle, then 0.
- Round-robin tie: both valid continuously (A addr 1 data 3, B addr 2 data 5) -> grants alternate A,B,A,B; write_reg alternates 0x01300001 / 0x01500002 with no idle cycles.
- Range error: b_valid=1, b_addr=307200 -> b_ready=1, next cycle write_reg=0 and range_error=1 for exactly one cycle.
- Full clear: clear_start=1 with clear_color=4'h7 at cycle T while a_valid=1 -> a_ready=0 in T; 307200 consecutive writes with addresses 0..307199 and data 7 in T+2..T+307201; clear_busy high T+1..T+307200; A granted at T+307201; a second clear_start at T+1000 is ignored.
- Reset during clear: reset at clear write 5000 -> strobe low immediately, clear_busy=0, and no writes resume after release until a new clear_start.
